// File: rtl/motor_passo_pkg.sv
// Shared constants for the MotorPasso stepper driver: register map,
// CTRL/STATUS bit positions, coil phase table and FSM state type.
package motor_passo_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PERIOD = 2'd1;
  localparam logic [1:0] ADDR_STEPS  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_DIR    = 1;
  localparam int CTRL_HALF   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_FREE   = 4;

  localparam int ST_BUSY      = 0;
  localparam int ST_DONE      = 1;
  localparam int ST_PHASE_LSB = 4;

  // Entry i sits at [i]; odd entries energise two adjacent coils.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/motor_passo_seq.sv
// Phase sequencer: holds the phase index and the registered coil pattern.
// Each one-cycle step pulse advances the index and loads the matching
// table entry onto the coils; between steps the coils hold for torque.
module motor_passo_seq
  import motor_passo_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  input  logic       dir,
  input  logic       half,
  output logic [2:0] index,
  output logic [3:0] coils
);

  logic       single;
  logic [2:0] delta;
  logic [2:0] index_nx;

  // Full mode moves by 2 from odd indices; an even index takes a single
  // move first so it realigns onto the two-phase-on (odd) positions.
  always_comb begin
    single   = half | ~index[0];
    delta    = single ? 3'd1 : 3'd2;
    index_nx = dir ? (index - delta) : (index + delta);
  end

  // Index and coil pattern advance together on each step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index <= 3'd0;
      coils <= 4'b0000;
    end else if (step) begin
      index <= index_nx;
      coils <= PHASE_TABLE[index_nx];
    end
  end

endmodule

// File: rtl/motor_passo_driver.sv
// Avalon-MM stepper motor driver for MotorPasso. Holds the register file,
// tick (rate) counter, remaining-steps counter and the IDLE/RUN FSM.
// Optional feature: define MOTOR_HALF_STEP_EN to enable CTRL.half.
module motor_passo_driver
  import motor_passo_pkg::*;
#(
  parameter int PERIOD_W = 32,
  parameter int STEPS_W  = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [3:0]  coils
);

  state_t state, state_nx;

  logic                ctrl_run, ctrl_dir, ctrl_half, ctrl_irq_en, ctrl_free;
  logic [PERIOD_W-1:0] period_r, tick;
  logic [STEPS_W-1:0]  steps_r;
  logic                done_r;
  logic [2:0]          index;

  logic wr, ctrl_wr, period_wr, steps_wr, status_wr;
  logic step, done_set, run_clr, tick_load, steps_dec;
  logic [31:0] rd_mux;
  logic unused_wd;

  assign wr        = chipselect & ~write_n;
  assign ctrl_wr   = wr && (address == ADDR_CTRL);
  assign period_wr = wr && (address == ADDR_PERIOD);
  assign steps_wr  = wr && (address == ADDR_STEPS);
  assign status_wr = wr && (address == ADDR_STATUS);
  assign unused_wd = ^writedata;

  assign irq = done_r & ctrl_irq_en;

  // FSM next state and per-cycle control strobes.
  always_comb begin
    state_nx  = state;
    step      = 1'b0;
    done_set  = 1'b0;
    run_clr   = 1'b0;
    tick_load = 1'b0;
    steps_dec = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_run) begin
          if (!ctrl_free && steps_r == '0) begin
            done_set = 1'b1;
            run_clr  = 1'b1;
          end else begin
            state_nx  = RUN;
            tick_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (ctrl_wr && !writedata[CTRL_RUN]) begin
          state_nx = IDLE;
        end else if (tick == '0) begin
          tick_load = 1'b1;
          if (ctrl_free) begin
            step = 1'b1;
          end else if (steps_r == '0) begin
            // Count was rewritten to 0 mid-move: finish without stepping.
            state_nx = IDLE;
            run_clr  = 1'b1;
            done_set = 1'b1;
          end else begin
            step      = 1'b1;
            steps_dec = 1'b1;
            if (steps_r == STEPS_W'(1)) begin
              state_nx = IDLE;
              run_clr  = 1'b1;
              done_set = 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // CTRL register; a bus write takes priority over the FSM clearing run.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_run    <= 1'b0;
      ctrl_dir    <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_free   <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_run    <= writedata[CTRL_RUN];
      ctrl_dir    <= writedata[CTRL_DIR];
      ctrl_irq_en <= writedata[CTRL_IRQ_EN];
      ctrl_free   <= writedata[CTRL_FREE];
    end else if (run_clr) begin
      ctrl_run <= 1'b0;
    end
  end

`ifdef MOTOR_HALF_STEP_EN
  // Half-step select, only present when the feature is built in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ctrl_half <= 1'b0;
    else if (ctrl_wr) ctrl_half <= writedata[CTRL_HALF];
  end
`else
  assign ctrl_half = 1'b0;
`endif

  // PERIOD register; 0 is stored as 1 so the tick counter always runs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      period_r <= PERIOD_W'(1);
    else if (period_wr)
      period_r <= (writedata[PERIOD_W-1:0] == '0) ? PERIOD_W'(1)
                                                  : writedata[PERIOD_W-1:0];
  end

  // Tick counter: reloads on RUN entry and at each step boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          tick <= '0;
    else if (tick_load)    tick <= period_r - 1'b1;
    else if (state == RUN) tick <= tick - 1'b1;
  end

  // Remaining steps; a bus write reloads without touching the tick phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       steps_r <= '0;
    else if (steps_wr)  steps_r <= writedata[STEPS_W-1:0];
    else if (steps_dec) steps_r <= steps_r - 1'b1;
  end

  // Sticky done; a completion in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       done_r <= 1'b0;
    else if (done_set)  done_r <= 1'b1;
    else if (status_wr) done_r <= 1'b0;
  end

  // Read mux, registered below for a one-cycle read latency.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL: begin
        rd_mux[CTRL_RUN]    = ctrl_run;
        rd_mux[CTRL_DIR]    = ctrl_dir;
        rd_mux[CTRL_HALF]   = ctrl_half;
        rd_mux[CTRL_IRQ_EN] = ctrl_irq_en;
        rd_mux[CTRL_FREE]   = ctrl_free;
      end
      ADDR_PERIOD: rd_mux[PERIOD_W-1:0] = period_r;
      ADDR_STEPS:  rd_mux[STEPS_W-1:0]  = steps_r;
      default: begin
        rd_mux[ST_BUSY]             = (state == RUN);
        rd_mux[ST_DONE]             = done_r;
        rd_mux[ST_PHASE_LSB +: 3]   = index;
      end
    endcase
  end

  // Registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  motor_passo_seq u_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step),
    .dir     (ctrl_dir),
    .half    (ctrl_half),
    .index   (index),
    .coils   (coils)
  );

endmodule

// File: tb/tb_motor_passo_driver.sv
// Directed bench for motor_passo_driver: register reset values, counted
// moves in both directions, free-run stop, zero-count start and the
// optional half-step sequence (MOTOR_HALF_STEP_EN).
module tb_motor_passo_driver;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  coils;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                          4'b0100, 4'b1100, 4'b1000, 4'b1001};

  motor_passo_driver #(.PERIOD_W(32), .STEPS_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .coils      (coils)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1;
    @(posedge clk); #1;
    d = readdata; chipselect = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; #1;
    chk("async_rst_coils", {28'd0, coils}, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Wait for the next coil change; cyc = -1 on timeout.
  task automatic wait_step(input int budget, output int cyc, output logic [3:0] val);
    logic [3:0] prev;
    prev = coils; cyc = -1; val = coils;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (coils !== prev) begin cyc = i; val = coils; break; end
    end
  endtask

  logic [31:0] rd;
  int          cyc;
  logic [3:0]  cv;

  initial begin
    @(posedge clk); #1;
    do_reset();

    // Reset values.
    bus_read(2'd0, rd); chk("rst_ctrl", rd, 32'h0);
    bus_read(2'd1, rd); chk("rst_period", rd, 32'h1);
    bus_read(2'd2, rd); chk("rst_steps", rd, 32'h0);
    bus_read(2'd3, rd); chk("rst_status", rd, 32'h0);
    chk("rst_coils", {28'd0, coils}, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);

    // PERIOD 0 stores 1.
    bus_write(2'd1, 32'd0);
    bus_read(2'd1, rd); chk("period_zero", rd, 32'h1);

    // Forward full-step move of 3.
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h09);
    wait_step(20, cyc, cv);
    chk("fwd_c1", {28'd0, cv}, 32'h3);
    chk("fwd_t1", cyc, 32'd5);
    wait_step(20, cyc, cv);
    chk("fwd_c2", {28'd0, cv}, 32'h6);
    chk("fwd_t2", cyc, 32'd4);
    wait_step(20, cyc, cv);
    chk("fwd_c3", {28'd0, cv}, 32'hC);
    chk("fwd_t3", cyc, 32'd4);
    chk("fwd_irq", {31'd0, irq}, 32'h1);
    bus_read(2'd3, rd); chk("fwd_status", rd, 32'h52);
    bus_read(2'd0, rd); chk("fwd_ctrl", rd, 32'h08);
    bus_read(2'd2, rd); chk("fwd_steps", rd, 32'h0);

    // Reverse move of 3 after a reset (coils must clear at once).
    do_reset();
    bus_write(2'd1, 32'd4);
    bus_write(2'd2, 32'd3);
    bus_write(2'd0, 32'h0B);
    wait_step(20, cyc, cv); chk("rev_c1", {28'd0, cv}, 32'h9);
    wait_step(20, cyc, cv); chk("rev_c2", {28'd0, cv}, 32'hC);
    wait_step(20, cyc, cv); chk("rev_c3", {28'd0, cv}, 32'h6);
    bus_read(2'd3, rd); chk("rev_status", rd, 32'h32);

    // Free run, PERIOD 2, stopped after 10 steps.
    do_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd5);
    bus_write(2'd0, 32'h11);
    repeat (21) @(posedge clk);
    #1;
    bus_write(2'd0, 32'h00);
    repeat (5) @(posedge clk);
    #1;
    chk("free_coils", {28'd0, coils}, 32'h6);
    bus_read(2'd2, rd); chk("free_steps", rd, 32'h5);
    bus_read(2'd3, rd); chk("free_status", rd, 32'h30);

    // Run with zero count: done next cycle, coils untouched.
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h09);
    @(posedge clk); #1;
    chk("zero_irq", {31'd0, irq}, 32'h1);
    bus_read(2'd3, rd); chk("zero_status", rd, 32'h32);
    bus_read(2'd0, rd); chk("zero_ctrl", rd, 32'h08);
    chk("zero_coils", {28'd0, coils}, 32'h6);
    bus_write(2'd3, 32'h0);
    chk("clr_irq", {31'd0, irq}, 32'h0);

`ifdef MOTOR_HALF_STEP_EN
    // Half-step through the whole table, wrapping to index 0.
    do_reset();
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd8);
    bus_write(2'd0, 32'h05);
    for (int i = 1; i <= 8; i++) begin
      wait_step(20, cyc, cv);
      chk($sformatf("half_c%0d", i), {28'd0, cv}, {28'd0, tbl[i % 8]});
    end
    bus_read(2'd3, rd); chk("half_status", rd, 32'h02);
`else
    // Half bit ignored: reads 0 and sequencing stays full-step.
    do_reset();
    bus_write(2'd0, 32'h04);
    bus_read(2'd0, rd); chk("nohalf_ctrl", rd, 32'h0);
    bus_write(2'd1, 32'd2);
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h05);
    wait_step(20, cyc, cv); chk("nohalf_c1", {28'd0, cv}, {28'd0, tbl[1]});
    wait_step(20, cyc, cv); chk("nohalf_c2", {28'd0, cv}, {28'd0, tbl[3]});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
